// File: rtl/waverv_pkg.sv
// Shared definitions for the WaveRV multi-cycle sequencer: state encodings,
// major-opcode constants (instr[6:2]) and halt cause codes.
package waverv_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_WAIT_I = 3'b001,
    S_EXEC   = 3'b010,
    S_LOAD   = 3'b011,
    S_WAIT_D = 3'b100,
    S_STORE  = 3'b101,
    S_HALT   = 3'b110
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_ECALL    = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_MISALIGN = 2'b11
  } halt_cause_e;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // Opcodes that write a non-memory result to rd and simply advance the PC.
  function automatic logic writes_rd(input logic [4:0] opc);
    return (opc == OPC_OP)  || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/waverv_lsu_mask.sv
// Byte-lane write mask and alignment check for a load/store, derived from
// the access size (funct3[1:0]) and the low two address bits.
module waverv_lsu_mask (
  input  logic [1:0] funct3,
  input  logic [1:0] ls_addr_lo,
  output logic [3:0] wmask,
  output logic       misaligned
);

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    wmask      = 4'b0000;
    misaligned = 1'b0;
    unique case (funct3)
      2'b00: wmask = 4'b0001 << ls_addr_lo;
      2'b01: begin
        wmask      = ls_addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = ls_addr_lo[0];
      end
      2'b10: begin
        wmask      = 4'b1111;
        misaligned = |ls_addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/waverv_sequencer.sv
// Multi-cycle control FSM for the WaveRV core: arbitrates the shared memory
// port, drives per-state enables, detects halts and keeps cycle/instret counters.
module waverv_sequencer
  import waverv_pkg::*;
#(
  parameter int unsigned CNT_WIDTH       = 64,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          instr,
  input  logic [1:0]           ls_addr_lo,
  input  logic                 mem_rbusy,
  input  logic                 mem_wbusy,
  input  logic                 resume,
  output logic                 ir_load,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic                 rf_wsel,
  output logic                 mem_addr_sel,
  output logic                 mem_rstrb,
  output logic [3:0]           mem_wmask,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count,
  output logic [2:0]           state
);

  state_e                 state_q, state_d;
  halt_cause_e            cause_q, cause_d;
  logic                   store_first_q;
  logic [CNT_WIDTH-1:0]   cycle_q, instret_q;

  logic                   ir_load_c, pc_we_c, rf_we_c, rf_wsel_c;
  logic                   addr_sel_c, rstrb_c, retire;
  logic [3:0]             wmask_c, lsu_wmask;
  logic                   misaligned;
  logic [4:0]             opcode;

  assign opcode = instr[6:2];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:14], instr[11:7], instr[1:0]};

  waverv_lsu_mask u_lsu_mask (
    .funct3     (instr[13:12]),
    .ls_addr_lo (ls_addr_lo),
    .wmask      (lsu_wmask),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    ir_load_c  = 1'b0;
    pc_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    rf_wsel_c  = 1'b0;
    addr_sel_c = 1'b0;
    rstrb_c    = 1'b0;
    wmask_c    = 4'b0000;
    retire     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        rstrb_c = 1'b1;
        state_d = S_WAIT_I;
      end
      S_WAIT_I: begin
        if (!mem_rbusy) begin
          ir_load_c = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (writes_rd(opcode)) begin
          rf_we_c = 1'b1;
          pc_we_c = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (opcode == OPC_BRANCH) begin
          pc_we_c = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
          // A faulting access leaves the PC on the offending instruction.
          if (misaligned) begin
            cause_d = CAUSE_MISALIGN;
            state_d = S_HALT;
          end else begin
            pc_we_c = 1'b1;
            state_d = (opcode == OPC_LOAD) ? S_LOAD : S_STORE;
          end
        end else if (opcode == OPC_SYSTEM) begin
          pc_we_c = 1'b1;
          retire  = 1'b1;
          cause_d = CAUSE_ECALL;
          state_d = S_HALT;
        end else if (HALT_ON_ILLEGAL) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_HALT;
        end else begin
          pc_we_c = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_LOAD: begin
        rstrb_c    = 1'b1;
        addr_sel_c = 1'b1;
        state_d    = S_WAIT_D;
      end
      S_WAIT_D: begin
        addr_sel_c = 1'b1;
        if (!mem_rbusy) begin
          rf_we_c   = 1'b1;
          rf_wsel_c = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_STORE: begin
        addr_sel_c = 1'b1;
        if (store_first_q) wmask_c = lsu_wmask;
        if (!mem_wbusy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (resume) begin
          cause_d = CAUSE_NONE;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_FETCH;
      cause_q       <= CAUSE_NONE;
      store_first_q <= 1'b0;
      cycle_q       <= '0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      store_first_q <= (state_q == S_EXEC) && (state_d == S_STORE);
      cycle_q       <= cycle_q + CNT_WIDTH'(1);
      if (retire) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  // Enables are gated by resetn so an in-flight access is dropped the moment
  // reset asserts, without waiting for a clock edge.
  assign ir_load       = resetn & ir_load_c;
  assign pc_we         = resetn & pc_we_c;
  assign rf_we         = resetn & rf_we_c;
  assign rf_wsel       = resetn & rf_wsel_c;
  assign mem_addr_sel  = resetn & addr_sel_c;
  assign mem_rstrb     = resetn & rstrb_c;
  assign mem_wmask     = resetn ? wmask_c : 4'b0000;
  assign halted        = (state_q == S_HALT);
  assign halt_cause    = cause_q;
  assign state         = state_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: doc/waverv_sequencer.md
Name: waverv_sequencer

Overview:
Multi-cycle control FSM for the WaveRV core. It sequences one shared synchronous memory port between instruction fetch and load/store. It generates the per-state enables for the IR, PC, register file and memory, including byte-lane write masks. It also detects halting conditions and maintains cycle and retired-instruction counters.

Parameters:
CNT_WIDTH, 64, width of cycle_count and instret_count
HALT_ON_ILLEGAL, 1, 1 = unknown opcode halts the core; 0 = treated as NOP

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
instr  in  32  current instruction register contents
ls_addr_lo  in  2  bits [1:0] of rs1+imm load/store address
mem_rbusy  in  1  memory read in progress; data valid on first cycle it is low after strobe
mem_wbusy  in  1  memory write in progress
resume  in  1  single-cycle pulse; leaves HALT
ir_load  out  1  latch memory read data into IR
pc_we  out  1  PC <- next_pc
rf_we  out  1  register file write (core suppresses rd=0)
rf_wsel  out  1  0 = ALU/PC/imm result, 1 = load data
mem_addr_sel  out  1  0 = PC, 1 = load/store address
mem_rstrb  out  1  read request pulse
mem_wmask  out  4  byte-lane write enables
halted  out  1  FSM in HALT
halt_cause  out  2  00 none, 01 ECALL/EBREAK, 10 illegal opcode, 11 misaligned access
cycle_count  out  CNT_WIDTH  clock cycles since reset
instret_count  out  CNT_WIDTH  retired instructions
state  out  3  current state encoding, for debug

Behaviour:
- Reset (async, resetn=0): state=FETCH; every output is 0; counters=0; halt_cause=00.
- States: FETCH(000), WAIT_I(001), EXEC(010), LOAD(011), WAIT_D(100), STORE(101), HALT(110).
- FETCH:
  - mem_rstrb=1, mem_addr_sel=0.
  - Next state WAIT_I, unconditionally.
- WAIT_I:
  - mem_addr_sel=0.
  - While mem_rbusy=1: stay.
  - Else: ir_load=1, go to EXEC.
- EXEC: decode on instr[6:2].
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: rf_we=1, rf_wsel=0, pc_we=1, go to FETCH; retire.
  - BRANCH: pc_we=1 (core selects target), go to FETCH; retire.
  - LOAD: if misaligned, go to HALT with cause 11 and no pc_we. Else pc_we=1, go to LOAD.
  - STORE: if misaligned, go to HALT with cause 11. Else pc_we=1, go to STORE.
  - SYSTEM: pc_we=1, go to HALT with cause 01; retire.
  - Any other opcode: if HALT_ON_ILLEGAL, go to HALT with cause 10 and no pc_we. Otherwise pc_we=1, go to FETCH, retire.
- Misaligned access definition, using funct3[1:0]:
  - halfword (01) with ls_addr_lo[0]=1;
  - word (10) with ls_addr_lo≠00;
  - funct3[1:0]=11 also counts as misaligned.
- LOAD:
  - mem_rstrb=1, mem_addr_sel=1.
  - Next state WAIT_D.
- WAIT_D:
  - mem_addr_sel=1.
  - While mem_rbusy=1: stay.
  - Else: rf_we=1, rf_wsel=1, go to FETCH; retire.
- STORE:
  - mem_addr_sel=1.
  - mem_wmask is driven only on the first STORE cycle:
    - byte: 0001<<ls_addr_lo;
    - half: 0011 if ls_addr_lo[1]=0, else 1100;
    - word: 1111.
  - Later cycles drive mask 0000 and wait while mem_wbusy=1.
  - Go to FETCH once mem_wbusy=0; retire. Retirement is allowed on the same cycle as the mask when mem_wbusy=0.
  - A first-cycle flag register tracks the mask cycle.
- HALT:
  - halted=1; halt_cause is held.
  - resume=1: clear cause, go to FETCH (PC already advanced for ECALL/EBREAK).
  - resume in any other state is ignored.
- Enables are combinational from state plus inputs; no enable is asserted outside the states listed above.
- cycle_count increments every cycle after reset, including HALT, and wraps modulo 2^CNT_WIDTH.
- instret_count increments by exactly 1 on the retiring cycle and wraps.
- Reset asserted mid-WAIT/STORE aborts the access immediately: mem_wmask and all enables go to 0 asynchronously.

Decomposition:
- Shared package waverv_pkg:
  - state encodings;
  - opcode[6:2] constants: OP=01100, OP_IMM=00100, BRANCH=11000, JAL=11011, JALR=11001, AUIPC=00101, LUI=01101, LOAD=00000, STORE=01000, SYSTEM=11100;
  - halt cause codes.
- One sub-module, waverv_lsu_mask: combinational inputs funct3[1:0] and ls_addr_lo, outputs wmask[3:0] and misaligned.

Test Plan:
- ADDI with mem_rbusy held 0 → FETCH, WAIT_I, EXEC, FETCH; ir_load at cycle 1; rf_we+pc_we at cycle 2; instret=1 at cycle 3.
- LW with mem_rbusy high for 3 cycles in WAIT_D → stays in WAIT_D 3 cycles; rf_we/rf_wsel=1 on cycle 4; exactly one mem_rstrb per access.
- SB at ls_addr_lo=10, then SH at 10, then SW at 00, with wbusy=0 → mem_wmask = 0100, 1100, 1111 for one cycle each.
- LH at ls_addr_lo=01 → HALT, halt_cause=11, no pc_we, instret unchanged; resume → FETCH, cause=00.
- ECALL → pc_we=1, HALT, cause=01, instret+1; resume pulse while in FETCH is ignored; cycle_count keeps counting.
- resetn low during WAIT_D with mem_rbusy=1 → outputs 0 immediately; after release state=FETCH, counters=0.
